alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller that decodes MIPS R-type ALU instructions, drives an external ALU and writes back.
// Define ALU_ISSUE_TRAP_EN to trap illegal instructions (illegal_op port) instead of running them as NOPs.
module alu_issue_ctrl #(
    parameter int unsigned CLEAR_RF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_operation,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        flag_zero,
    output logic        flag_carry,
`ifdef ALU_ISSUE_TRAP_EN
    output logic        illegal_op,
`endif
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExecute,
        StWriteback
    } state_e;

    state_e state_q, state_d;

    logic [31:0] instr_q;
    logic [31:0] rf [1:31];

    logic        zero_q;
    logic        carry_q;
    logic        nop_q;
    logic        addsub_q;

    logic [5:0]  opcode_f;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt_f;
    logic [5:0]  funct_f;

    logic        dec_legal;
    logic        dec_shift;
    logic        dec_addsub;
    logic [5:0]  dec_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    assign opcode_f = instr_q[31:26];
    assign rs_f     = instr_q[25:21];
    assign rt_f     = instr_q[20:16];
    assign rd_f     = instr_q[15:11];
    assign shamt_f  = instr_q[10:6];
    assign funct_f  = instr_q[5:0];

    assign instr_ready = (state_q == StIdle);

    // Register 0 is hard-wired to zero and has no storage.
    assign rs_data  = (rs_f == 5'd0) ? 32'd0 : rf[rs_f];
    assign rt_data  = (rt_f == 5'd0) ? 32'd0 : rf[rt_f];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

    always_comb begin
        dec_legal  = 1'b1;
        dec_shift  = 1'b0;
        dec_addsub = 1'b0;
        dec_op     = 6'd0;
        case (funct_f)
            6'h20: begin dec_op = 6'd27; dec_addsub = 1'b1; end
            6'h22: begin dec_op = 6'd28; dec_addsub = 1'b1; end
            6'h02: begin dec_op = 6'd29; dec_shift  = 1'b1; end
            6'h00: begin dec_op = 6'd30; dec_shift  = 1'b1; end
            6'h26: dec_op = 6'd31;
            6'h24: dec_op = 6'd32;
            default: dec_legal = 1'b0;
        endcase
        if (opcode_f != 6'd0) begin
            dec_legal = 1'b0;
        end
        if (!dec_legal) begin
            dec_op     = 6'd0;
            dec_shift  = 1'b0;
            dec_addsub = 1'b0;
        end
    end

`ifdef ALU_ISSUE_TRAP_EN
    assign illegal_op = (state_q == StDecode) && !dec_legal;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
`ifdef ALU_ISSUE_TRAP_EN
                state_d = dec_legal ? StExecute : StIdle;
`else
                state_d = StExecute;
`endif
            end
            StExecute:   state_d = StWriteback;
            StWriteback: state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q       <= 32'd0;
            alu_src1      <= 32'd0;
            alu_src2      <= 32'd0;
            alu_operation <= 6'd0;
            alu_shamt     <= 5'd0;
            wb_valid      <= 1'b0;
            wb_addr       <= 5'd0;
            wb_data       <= 32'd0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            zero_q        <= 1'b0;
            carry_q       <= 1'b0;
            nop_q         <= 1'b0;
            addsub_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                StDecode: begin
                    if (dec_legal) begin
                        alu_src1      <= dec_shift ? rt_data : rs_data;
                        alu_src2      <= dec_shift ? 32'd0 : rt_data;
                        alu_shamt     <= dec_shift ? shamt_f : 5'd0;
                        alu_operation <= dec_op;
                        nop_q         <= 1'b0;
                        addsub_q      <= dec_addsub;
                    end else begin
`ifndef ALU_ISSUE_TRAP_EN
                        // Illegal words run the full sequence as a NOP to keep timing uniform.
                        alu_src1      <= 32'd0;
                        alu_src2      <= 32'd0;
                        alu_shamt     <= 5'd0;
                        alu_operation <= 6'd0;
                        nop_q         <= 1'b1;
                        addsub_q      <= 1'b0;
`endif
                    end
                end
                StExecute: begin
                    wb_valid <= 1'b1;
                    wb_addr  <= nop_q ? 5'd0 : rd_f;
                    wb_data  <= nop_q ? 32'd0 : alu_result;
                    zero_q   <= alu_zero;
                    carry_q  <= alu_carry;
                end
                StWriteback: begin
                    wb_valid <= 1'b0;
                    if (!nop_q) begin
                        flag_zero <= zero_q;
                        if (addsub_q) begin
                            flag_carry <= carry_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset wins over the writeback write, so an aborted instruction never commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_RF != 0) begin
                for (int i = 1; i < 32; i++) begin
                    rf[i] <= 32'd0;
                end
            end
        end else if (state_q == StWriteback && !nop_q && wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; a behavioural ALU closes the loop.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [5:0]  alu_operation;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flag_zero;
    logic        flag_carry;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef ALU_ISSUE_TRAP_EN
    logic        illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    // Override lets the bench seed registers through an add-from-R0 sequence.
    logic        ovr_en;
    logic [31:0] ovr_val;
    logic [32:0] wide;

    always #5 clk = ~clk;

    always_comb begin
        wide = 33'd0;
        if (ovr_en) begin
            wide = {1'b0, ovr_val};
        end else begin
            case (alu_operation)
                6'd27: wide = {1'b0, alu_src1} + {1'b0, alu_src2};
                6'd28: wide = {1'b0, alu_src1} - {1'b0, alu_src2};
                6'd29: wide = {1'b0, alu_src1 >> alu_shamt};
                6'd30: wide = {1'b0, alu_src1 << alu_shamt};
                6'd31: wide = {1'b0, alu_src1 ^ alu_src2};
                6'd32: wide = {1'b0, alu_src1 & alu_src2};
                default: wide = 33'd0;
            endcase
        end
        alu_result = wide[31:0];
        alu_carry  = wide[32];
        alu_zero   = (wide[31:0] == 32'd0);
    end

    alu_issue_ctrl #(.CLEAR_RF(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .alu_src1      (alu_src1),
        .alu_src2      (alu_src2),
        .alu_operation (alu_operation),
        .alu_shamt     (alu_shamt),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry),
`ifdef ALU_ISSUE_TRAP_EN
        .illegal_op    (illegal_op),
`endif
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input logic [4:0] a, input logic [31:0] e);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, e);
    endtask

    // Issue one instruction from IDLE and check the 4-cycle handshake and writeback.
    task automatic run_op(input logic [31:0] ins, input logic [4:0] ea, input logic [31:0] ed);
        chk("ready_idle", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        tick();
        instr_valid = 1'b0;
        instr       = 32'hFFFF_FFFF;
        chk("ready_decode", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("wb_early", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, ea});
        chk("wb_data", wb_data, ed);
        tick();
        chk("wb_end", {31'd0, wb_valid}, 32'd0);
        chk("ready_back", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic load(input logic [4:0] rd, input logic [31:0] v);
        ovr_en  = 1'b1;
        ovr_val = v;
        run_op(rtype(5'd0, 5'd0, rd, 5'd0, 6'h20), rd, v);
        ovr_en  = 1'b0;
        chk_reg(rd, v);
    endtask

    task automatic chk_flags(input logic z, input logic c);
        chk("flag_zero", {31'd0, flag_zero}, {31'd0, z});
        chk("flag_carry", {31'd0, flag_carry}, {31'd0, c});
    endtask

    task automatic chk_drive(input logic [31:0] s1, input logic [31:0] s2,
                             input logic [5:0] op, input logic [4:0] sh);
        chk("alu_src1", alu_src1, s1);
        chk("alu_src2", alu_src2, s2);
        chk("alu_operation", {26'd0, alu_operation}, {26'd0, op});
        chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, sh});
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk_drive(32'd0, 32'd0, 6'd0, 5'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk_flags(1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 5'd0;
        ovr_en      = 1'b0;
        ovr_val     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        chk_reg(5'd5, 32'd0);
        rst = 1'b0;
        tick();

        // Seed operands; each seed add has carry 0 and a nonzero result.
        load(5'd1, 32'hFFFF_FFFF);
        load(5'd2, 32'h0000_0001);
        load(5'd4, 32'h8000_0000);
        load(5'd6, 32'h0000_F0F0);
        load(5'd7, 32'h00FF_00FF);
        chk_flags(1'b0, 1'b0);

        // add wraps to zero with carry out
        run_op(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 5'd3, 32'd0);
        chk_flags(1'b1, 1'b1);
        chk_drive(32'hFFFF_FFFF, 32'd1, 6'd27, 5'd0);
        chk_reg(5'd3, 32'd0);

        // sll shifts the top bit out; carry must hold
        run_op(rtype(5'd0, 5'd4, 5'd5, 5'd1, 6'h00), 5'd5, 32'd0);
        chk_flags(1'b1, 1'b1);
        chk_drive(32'h8000_0000, 32'd0, 6'd30, 5'd1);

        run_op(rtype(5'd6, 5'd7, 5'd8, 5'd0, 6'h26), 5'd8, 32'h00FF_F00F);
        chk_flags(1'b0, 1'b1);
        chk_drive(32'h0000_F0F0, 32'h00FF_00FF, 6'd31, 5'd0);
        chk_reg(5'd8, 32'h00FF_F00F);

        run_op(rtype(5'd6, 5'd7, 5'd9, 5'd0, 6'h24), 5'd9, 32'h0000_00F0);
        chk_reg(5'd9, 32'h0000_00F0);
        chk("and_op", {26'd0, alu_operation}, 32'd32);

        // srl depends on the xor result written two instructions earlier
        run_op(rtype(5'd0, 5'd8, 5'd10, 5'd4, 6'h02), 5'd10, 32'h000F_FF00);
        chk_drive(32'h00FF_F00F, 32'd0, 6'd29, 5'd4);
        chk_reg(5'd10, 32'h000F_FF00);

        // sub without borrow clears carry
        run_op(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h22), 5'd12, 32'hFFFF_FFFE);
        chk_flags(1'b0, 1'b0);
        chk("sub_op", {26'd0, alu_operation}, 32'd28);
        chk_reg(5'd12, 32'hFFFF_FFFE);

        // add to R0 still pulses writeback, R0 stays zero
        run_op(rtype(5'd1, 5'd1, 5'd0, 5'd0, 6'h20), 5'd0, 32'hFFFF_FFFE);
        chk_reg(5'd0, 32'd0);
        chk_flags(1'b0, 1'b1);

`ifdef ALU_ISSUE_TRAP_EN
        instr_valid = 1'b1;
        instr       = 32'h0000_002A;
        tick();
        instr_valid = 1'b0;
        chk("trap_pulse", {31'd0, illegal_op}, 32'd1);
        chk("trap_busy", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("trap_pulse_end", {31'd0, illegal_op}, 32'd0);
        chk("trap_ready", {31'd0, instr_ready}, 32'd1);
        chk("trap_no_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("trap_no_wb2", {31'd0, wb_valid}, 32'd0);
        instr_valid = 1'b1;
        instr       = {6'd1, 5'd1, 5'd2, 5'd13, 5'd0, 6'h20};
        tick();
        instr_valid = 1'b0;
        chk("trap_opcode", {31'd0, illegal_op}, 32'd1);
        tick();
        tick();
`else
        run_op(32'h0000_002A, 5'd0, 32'd0);
        chk("nop_op", {26'd0, alu_operation}, 32'd0);
        run_op({6'd1, 5'd1, 5'd2, 5'd13, 5'd0, 6'h20}, 5'd0, 32'd0);
`endif
        chk_reg(5'd13, 32'd0);
        chk_flags(1'b0, 1'b1);

        // reset during EXECUTE aborts the add to R11
        instr_valid = 1'b1;
        instr       = rtype(5'd6, 5'd7, 5'd11, 5'd0, 6'h20);
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs();
        tick();
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_no_wb", {31'd0, wb_valid}, 32'd0);
        chk_reg(5'd11, 32'd0);
        chk_reg(5'd6, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
